// File: rtl/bp_be_int_issue_ctrl_if.sv
// Issue controller handshake bundle: dispatch/replay in,
// issue register out, branch resolution and redirect.
interface bp_be_int_issue_ctrl_if #(
  parameter int vaddr_width_p = 39,
  parameter int pkt_width_p   = 128
);
  logic                     dispatch_v_i;
  logic                     dispatch_ready_o;
  logic [pkt_width_p-1:0]   dispatch_pkt_i;
  logic [vaddr_width_p-1:0] dispatch_pc_i;
  logic [vaddr_width_p-1:0] dispatch_npc_i;
  logic                     replay_v_i;
  logic                     replay_ready_o;
  logic [pkt_width_p-1:0]   replay_pkt_i;
  logic [vaddr_width_p-1:0] replay_pc_i;
  logic [vaddr_width_p-1:0] replay_npc_i;
  logic                     issue_v_o;
  logic [pkt_width_p-1:0]   issue_pkt_o;
  logic [vaddr_width_p-1:0] issue_pc_o;
  logic                     pipe_stall_i;
  logic [vaddr_width_p-1:0] br_tgt_i;
  logic                     redirect_v_o;
  logic [vaddr_width_p-1:0] redirect_pc_o;
  logic                     redirect_yumi_i;
  logic [15:0]              redirect_count_o;

  modport slave (
    input  dispatch_v_i, dispatch_pkt_i,
    input  dispatch_pc_i, dispatch_npc_i,
    output dispatch_ready_o,
    input  replay_v_i, replay_pkt_i,
    input  replay_pc_i, replay_npc_i,
    output replay_ready_o,
    output issue_v_o, issue_pkt_o, issue_pc_o,
    input  pipe_stall_i, br_tgt_i,
    output redirect_v_o, redirect_pc_o,
    input  redirect_yumi_i,
    output redirect_count_o
  );

  modport master (
    output dispatch_v_i, dispatch_pkt_i,
    output dispatch_pc_i, dispatch_npc_i,
    input  dispatch_ready_o,
    output replay_v_i, replay_pkt_i,
    output replay_pc_i, replay_npc_i,
    input  replay_ready_o,
    input  issue_v_o, issue_pkt_o, issue_pc_o,
    output pipe_stall_i, br_tgt_i,
    input  redirect_v_o, redirect_pc_o,
    output redirect_yumi_i,
    input  redirect_count_o
  );
endinterface

// File: rtl/bp_be_int_issue_ctrl.sv
// Integer issue sequencer: replay-first arbitration into an
// in-order queue, issue register, mispredict redirect.
module bp_be_int_issue_ctrl #(
  parameter int vaddr_width_p = 39,
  parameter int pkt_width_p   = 128,
  parameter int queue_els_p   = 2
) (
  input logic clk_i,
  input logic reset_i,
  bp_be_int_issue_ctrl_if.slave io
);
  localparam int ptr_w_lp = $clog2(queue_els_p);
  localparam logic [ptr_w_lp:0] ptr_one_lp = 1;

  typedef struct packed {
    logic [pkt_width_p-1:0]   pkt;
    logic [vaddr_width_p-1:0] pc;
    logic [vaddr_width_p-1:0] npc;
  } entry_s;

  typedef enum logic {e_run, e_redirect} state_e;

  state_e                   state_q, state_d;
  entry_s                   mem_q [queue_els_p];
  entry_s                   mem_d [queue_els_p];
  logic [ptr_w_lp:0]        wptr_q, wptr_d;
  logic [ptr_w_lp:0]        rptr_q, rptr_d;
  entry_s                   issue_q, issue_d;
  logic                     issue_v_q, issue_v_d;
  logic [vaddr_width_p-1:0] redir_pc_q, redir_pc_d;
  logic [15:0]              redir_cnt_q, redir_cnt_d;

  logic   empty, full, run;
  logic   rp_rdy, dp_rdy, enq_v, deq_v;
  logic   fire, mispredict;
  entry_s enq_e;

  // Queue status, arbitration and resolution
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
           && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
    run    = (state_q == e_run);
    rp_rdy = run & ~full;
    dp_rdy = rp_rdy & ~io.replay_v_i;
    enq_v  = (io.replay_v_i & rp_rdy)
           | (io.dispatch_v_i & dp_rdy);
    if (io.replay_v_i) begin
      enq_e = '{io.replay_pkt_i, io.replay_pc_i,
                io.replay_npc_i};
    end else begin
      enq_e = '{io.dispatch_pkt_i, io.dispatch_pc_i,
                io.dispatch_npc_i};
    end
    fire       = issue_v_q & ~io.pipe_stall_i;
    mispredict = fire & (io.br_tgt_i != issue_q.npc);
    deq_v      = run & ~empty & (~issue_v_q | fire);
  end

  // Next-state for queue, issue register, FSM and counter
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    issue_d     = issue_q;
    issue_v_d   = issue_v_q;
    redir_pc_d  = redir_pc_q;
    redir_cnt_d = redir_cnt_q;

    if (enq_v) begin
      mem_d[wptr_q[ptr_w_lp-1:0]] = enq_e;
      wptr_d = wptr_q + ptr_one_lp;
    end

    if (deq_v) begin
      issue_d   = mem_q[rptr_q[ptr_w_lp-1:0]];
      issue_v_d = 1'b1;
      rptr_d    = rptr_q + ptr_one_lp;
    end else if (fire) begin
      issue_v_d = 1'b0;
    end

    unique case (state_q)
      e_run:      if (mispredict) state_d = e_redirect;
      e_redirect: if (io.redirect_yumi_i) state_d = e_run;
      default:    state_d = e_run;
    endcase

    // A mispredict discards everything younger, including
    // anything accepted this very cycle.
    if (mispredict) begin
      wptr_d     = '0;
      rptr_d     = '0;
      issue_v_d  = 1'b0;
      redir_pc_d = io.br_tgt_i;
      if (redir_cnt_q != 16'hFFFF) begin
        redir_cnt_d = redir_cnt_q + 16'd1;
      end
    end
  end

  // Control and issue register state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_run;
      wptr_q      <= '0;
      rptr_q      <= '0;
      issue_q     <= '0;
      issue_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      issue_q     <= issue_d;
      issue_v_q   <= issue_v_d;
      redir_pc_q  <= redir_pc_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  // Queue storage; validity is tracked by the pointers only
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign io.replay_ready_o   = rp_rdy;
  assign io.dispatch_ready_o = dp_rdy;
  assign io.issue_v_o        = issue_v_q;
  assign io.issue_pkt_o      = issue_q.pkt;
  assign io.issue_pc_o       = issue_q.pc;
  assign io.redirect_v_o     = (state_q == e_redirect);
  assign io.redirect_pc_o    = redir_pc_q;
  assign io.redirect_count_o = redir_cnt_q;
endmodule

// File: tb/tb_bp_be_int_issue_ctrl.sv
// Directed bench for bp_be_int_issue_ctrl with a simple
// pipe model: branch target = issue PC + 4 unless overridden.
module tb_bp_be_int_issue_ctrl;
  logic clk;
  logic rst;
  logic tgt_en;
  logic [38:0] tgt_ovr;
  int checks;
  int errors;

  bp_be_int_issue_ctrl_if ifc ();

  bp_be_int_issue_ctrl dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.br_tgt_i = tgt_en ? tgt_ovr
                               : ifc.issue_pc_o + 39'd4;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_d(input logic v, input logic [38:0] pc,
                       input logic [38:0] npc);
    ifc.dispatch_v_i   = v;
    ifc.dispatch_pc_i  = pc;
    ifc.dispatch_npc_i = npc;
    ifc.dispatch_pkt_i = {89'h0, pc};
  endtask

  task automatic drv_r(input logic v, input logic [38:0] pc,
                       input logic [38:0] npc);
    ifc.replay_v_i   = v;
    ifc.replay_pc_i  = pc;
    ifc.replay_npc_i = npc;
    ifc.replay_pkt_i = {89'h1, pc};
  endtask

  // Enqueue one bad-npc packet; returns in the first
  // redirect cycle.
  task automatic do_redirect(input logic [38:0] pc,
                             input logic [38:0] npc);
    drv_d(1'b1, pc, npc);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    tick();
    tick();
  endtask

  task automatic do_yumi();
    ifc.redirect_yumi_i = 1'b1;
    tick();
    ifc.redirect_yumi_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    tgt_en = 1'b0;
    tgt_ovr = '0;
    drv_d(1'b0, 39'h0, 39'h0);
    drv_r(1'b0, 39'h0, 39'h0);
    ifc.pipe_stall_i = 1'b0;
    ifc.redirect_yumi_i = 1'b0;
    tick();
    tick();
    chk("rst_issue_v", ifc.issue_v_o, 0);
    chk("rst_redir_v", ifc.redirect_v_o, 0);
    chk("rst_redir_pc", ifc.redirect_pc_o, 0);
    chk("rst_count", ifc.redirect_count_o, 0);
    chk("rst_issue_pc", ifc.issue_pc_o, 0);
    rst = 1'b0;
    #1;
    chk("rst_rp_rdy", ifc.replay_ready_o, 1);
    chk("rst_dp_rdy", ifc.dispatch_ready_o, 1);

    // Single dispatch, latency 2, correct prediction
    drv_d(1'b1, 39'h1000, 39'h1004);
    #1;
    chk("t1_dp_rdy", ifc.dispatch_ready_o, 1);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t1_n1_v", ifc.issue_v_o, 0);
    tick();
    chk("t1_n2_v", ifc.issue_v_o, 1);
    chk("t1_n2_pc", ifc.issue_pc_o, 39'h1000);
    chk("t1_n2_pkt", ifc.issue_pkt_o, 128'h1000);
    tick();
    chk("t1_n3_v", ifc.issue_v_o, 0);
    chk("t1_redir", ifc.redirect_v_o, 0);

    // Replay has priority over dispatch
    drv_d(1'b1, 39'h5000, 39'h5004);
    drv_r(1'b1, 39'h2000, 39'h2004);
    #1;
    chk("t2_a_dp", ifc.dispatch_ready_o, 0);
    chk("t2_a_rp", ifc.replay_ready_o, 1);
    tick();
    chk("t2_a_v", ifc.issue_v_o, 0);
    drv_r(1'b1, 39'h2010, 39'h2014);
    #1;
    chk("t2_b_dp", ifc.dispatch_ready_o, 0);
    chk("t2_b_rp", ifc.replay_ready_o, 1);
    tick();
    chk("t2_b_pc", ifc.issue_pc_o, 39'h2000);
    chk("t2_b_pkt", ifc.issue_pkt_o, {89'h1, 39'h2000});
    drv_r(1'b1, 39'h2020, 39'h2024);
    #1;
    chk("t2_c_dp", ifc.dispatch_ready_o, 0);
    chk("t2_c_rp", ifc.replay_ready_o, 1);
    tick();
    drv_r(1'b0, 39'h0, 39'h0);
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t2_c_pc", ifc.issue_pc_o, 39'h2010);
    tick();
    chk("t2_d_pc", ifc.issue_pc_o, 39'h2020);
    chk("t2_d_v", ifc.issue_v_o, 1);
    tick();
    chk("t2_e_v", ifc.issue_v_o, 0);

    // Stall with a continuous dispatch stream
    ifc.pipe_stall_i = 1'b1;
    drv_d(1'b1, 39'h4000, 39'h4004);
    #1;
    chk("t3_s1_rdy", ifc.dispatch_ready_o, 1);
    tick();
    drv_d(1'b1, 39'h4010, 39'h4014);
    #1;
    chk("t3_s2_rdy", ifc.dispatch_ready_o, 1);
    tick();
    chk("t3_s2_pc", ifc.issue_pc_o, 39'h4000);
    drv_d(1'b1, 39'h4020, 39'h4024);
    #1;
    chk("t3_s3_rdy", ifc.dispatch_ready_o, 1);
    tick();
    chk("t3_s3_pc", ifc.issue_pc_o, 39'h4000);
    drv_d(1'b1, 39'h4030, 39'h4034);
    #1;
    chk("t3_s4_rdy", ifc.dispatch_ready_o, 0);
    tick();
    chk("t3_s4_pkt", ifc.issue_pkt_o, 128'h4000);
    chk("t3_s4_rdy2", ifc.dispatch_ready_o, 0);
    tick();
    chk("t3_s5_pc", ifc.issue_pc_o, 39'h4000);
    ifc.pipe_stall_i = 1'b0;
    #1;
    chk("t3_rel_rdy", ifc.dispatch_ready_o, 0);
    tick();
    chk("t3_r1_pc", ifc.issue_pc_o, 39'h4010);
    chk("t3_r1_rdy", ifc.dispatch_ready_o, 1);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t3_r2_pc", ifc.issue_pc_o, 39'h4020);
    tick();
    chk("t3_r3_pc", ifc.issue_pc_o, 39'h4030);
    chk("t3_r3_v", ifc.issue_v_o, 1);
    tick();
    chk("t3_r4_v", ifc.issue_v_o, 0);

    // Mispredict with two entries queued behind it
    ifc.pipe_stall_i = 1'b1;
    drv_d(1'b1, 39'h2000, 39'h2004);
    tick();
    drv_d(1'b1, 39'h2100, 39'h2104);
    tick();
    drv_d(1'b1, 39'h2200, 39'h2204);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t4_full_rdy", ifc.replay_ready_o, 0);
    tgt_en = 1'b1;
    tgt_ovr = 39'h3000;
    ifc.pipe_stall_i = 1'b0;
    tick();
    tgt_en = 1'b0;
    chk("t4_redir_v", ifc.redirect_v_o, 1);
    chk("t4_redir_pc", ifc.redirect_pc_o, 39'h3000);
    chk("t4_issue_v", ifc.issue_v_o, 0);
    chk("t4_rp_rdy", ifc.replay_ready_o, 0);
    chk("t4_dp_rdy", ifc.dispatch_ready_o, 0);
    chk("t4_count", ifc.redirect_count_o, 1);
    tick();
    chk("t4_hold1", ifc.redirect_v_o, 1);
    tick();
    chk("t4_hold2", ifc.redirect_v_o, 1);
    tick();
    do_yumi();
    chk("t4_run_v", ifc.redirect_v_o, 0);
    chk("t4_run_rdy", ifc.replay_ready_o, 1);
    chk("t4_pc_held", ifc.redirect_pc_o, 39'h3000);
    chk("t4_count2", ifc.redirect_count_o, 1);
    tick();
    chk("t4_flush1", ifc.issue_v_o, 0);
    tick();
    chk("t4_flush2", ifc.issue_v_o, 0);

    // Enqueue in the mispredict cycle is flushed
    drv_d(1'b1, 39'h6000, 39'h6100);
    tick();
    drv_d(1'b1, 39'h7000, 39'h7004);
    tick();
    drv_d(1'b1, 39'h7010, 39'h7014);
    #1;
    chk("t5_rdy", ifc.dispatch_ready_o, 1);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t5_redir_v", ifc.redirect_v_o, 1);
    chk("t5_redir_pc", ifc.redirect_pc_o, 39'h6004);
    chk("t5_count", ifc.redirect_count_o, 2);
    do_yumi();
    chk("t5_run", ifc.redirect_v_o, 0);
    tick();
    chk("t5_flush1", ifc.issue_v_o, 0);
    tick();
    chk("t5_flush2", ifc.issue_v_o, 0);

    // Counter saturation, preloaded near the top
    force dut.redir_cnt_q = 16'hFFFE;
    tick();
    release dut.redir_cnt_q;
    tick();
    do_redirect(39'h8000, 39'h8800);
    chk("t6_cnt_max", ifc.redirect_count_o, 16'hFFFF);
    do_yumi();
    do_redirect(39'h8100, 39'h8900);
    chk("t6_cnt_sat", ifc.redirect_count_o, 16'hFFFF);
    chk("t6_pc", ifc.redirect_pc_o, 39'h8104);

    // Reset while redirecting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_redir_v", ifc.redirect_v_o, 0);
    chk("t7_redir_pc", ifc.redirect_pc_o, 0);
    chk("t7_count", ifc.redirect_count_o, 0);
    chk("t7_issue_v", ifc.issue_v_o, 0);
    chk("t7_rp_rdy", ifc.replay_ready_o, 1);
    chk("t7_dp_rdy", ifc.dispatch_ready_o, 1);
    drv_d(1'b1, 39'hA000, 39'hA004);
    tick();
    drv_d(1'b0, 39'h0, 39'h0);
    chk("t7_n1_v", ifc.issue_v_o, 0);
    tick();
    chk("t7_n2_v", ifc.issue_v_o, 1);
    chk("t7_n2_pc", ifc.issue_pc_o, 39'hA000);
    tick();
    chk("t7_n3_v", ifc.issue_v_o, 0);
    chk("t7_redir", ifc.redirect_v_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_be_int_issue_ctrl.md
Name: bp_be_int_issue_ctrl

Overview:
Issue sequencer in front of the integer pipe.
- Arbitrates between the dispatch path and the replay path (strict priority to replay) into a small in-order queue.
- Feeds one packet per cycle into the pipe's issue register.
- Compares the pipe's branch target with the predicted next PC and, on mismatch, flushes and raises a redirect to the front end.

Parameters:
vaddr_width_p, 39, virtual address width of PC, predicted next PC and redirect target
pkt_width_p, 128, opaque payload width (decode, instruction, operands) passed to the pipe
queue_els_p, 2, queue depth; power of 2, >= 2

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
dispatch_v_i  in  1  dispatch packet valid
dispatch_ready_o  out  1  dispatch accepted when v & ready
dispatch_pkt_i  in  pkt_width_p  dispatch payload
dispatch_pc_i  in  vaddr_width_p  dispatch PC
dispatch_npc_i  in  vaddr_width_p  dispatch predicted next PC
replay_v_i  in  1  replay packet valid
replay_ready_o  out  1  replay accepted when v & ready
replay_pkt_i  in  pkt_width_p  replay payload
replay_pc_i  in  vaddr_width_p  replay PC
replay_npc_i  in  vaddr_width_p  replay predicted next PC
issue_v_o  out  1  issue register holds a valid packet
issue_pkt_o  out  pkt_width_p  payload to the integer pipe
issue_pc_o  out  vaddr_width_p  PC to the integer pipe
pipe_stall_i  in  1  pipe cannot consume issue register this cycle
br_tgt_i  in  vaddr_width_p  pipe branch target (PC+4 if not taken), combinational from issue register
redirect_v_o  out  1  redirect request to the front end
redirect_pc_o  out  vaddr_width_p  redirect target
redirect_yumi_i  in  1  front end consumes the redirect; legal only while redirect_v_o
redirect_count_o  out  16  saturating count of redirects issued

Behaviour:
- Reset clears queue pointers, issue valid, state = e_run, redirect_v_o = 0, redirect_pc_o = 0, redirect_count_o = 0. All outputs 0 from the cycle after reset_i is sampled high. Reset mid-redirect or with a full queue discards everything.
- FSM, two states:
  - e_run: normal operation.
  - e_redirect: redirect_v_o = 1; no enqueue; issue_v_o = 0. Moves to e_run the cycle after redirect_yumi_i.
- Arbitration:
  - replay_ready_o = (state == e_run) & ~full.
  - dispatch_ready_o = replay_ready_o & ~replay_v_i.
  - At most one enqueue per cycle.
  - Ready does not depend on same-cycle dequeue: a full queue accepts nothing even while draining.
- Queue:
  - In-order circular buffer of {pkt, pc, npc}, queue_els_p entries.
  - Wrap-around pointers with an extra bit for full/empty.
  - Simultaneous enqueue and dequeue at a non-full, non-empty occupancy leaves the count unchanged.
- Issue register:
  - Fire = issue_v_o & ~pipe_stall_i.
  - Loads the queue head when the register is empty or fires, and the queue is non-empty.
  - Otherwise holds (stall) or clears (fire with empty queue).
  - Minimum latency: enqueue at cycle N -> issue_v_o at N+2. No bypass.
- Resolution:
  - On fire, compare br_tgt_i with the held npc. Outputs are ignored while stalled.
  - Mismatch at cycle N, effective at N+1:
    - queue flushed and issue register cleared;
    - state = e_redirect; redirect_v_o = 1;
    - redirect_pc_o = br_tgt_i captured at N;
    - redirect_count_o += 1, saturating at 16'hFFFF.
  - Enqueues attempted at cycle N are still accepted, then flushed.
  - Match: no side effect.
- redirect_pc_o holds its value until the next redirect.
- redirect_yumi_i without redirect_v_o is ignored.

Test Plan:
- Single dispatch: pc = 0x1000, npc = 0x1004, br_tgt_i = 0x1004, no stall -> issue_v_o at cycle 2 for 1 cycle, redirect_v_o stays 0.
- Simultaneous dispatch and replay for 3 cycles, no stall, queue_els_p = 2 -> replay packets issue in order, dispatch_ready_o = 0 throughout, replay_ready_o drops only when full.
- Hold pipe_stall_i = 1 for 5 cycles with a continuous dispatch stream -> issue_pkt_o stable, queue fills at 2, dispatch_ready_o = 0, no loss or duplicate after release.
- Issued npc = 0x2004, br_tgt_i = 0x3000 with 2 entries queued -> next cycle redirect_v_o = 1, redirect_pc_o = 0x3000, queue empty, issue_v_o = 0, readies 0; yumi 3 cycles later -> e_run the following cycle, redirect_count_o = 1.
- Force 65537 mispredicts -> redirect_count_o saturates at 0xFFFF.
- Assert reset_i during e_redirect with a full queue -> next cycle all outputs 0 and readies high. A fresh dispatch then issues with latency 2.
